// File: rtl/shader_dispatch_scheduler.sv
// shader_dispatch_scheduler
// Hands the items of a job out to an array of shader cores. Each launch holds
// the chosen core in reset, writes the item index into its data RAM, then
// releases and runs it. Items retire as cores halt. Any exception on a running
// core aborts the whole job.
//
// Handshake: there is no valid/ready pair on this block. start is a level
// sampled on the clock edge and is accepted only while busy=0, in IDLE, DONE
// or ERROR. enable_write_data_ram is a one-cycle, one-hot write strobe that is
// qualified by rw_address/write_data in the same cycle. core_halted and
// core_exception are level inputs sampled every cycle.
module shader_dispatch_scheduler #(
  parameter int                       NUM_CORES     = 4,
  parameter int                       ADDRESS_WIDTH = 16,
  parameter int                       WORD_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] ITEM_ADDR     = '0,
  localparam int                      CW            = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [15:0]              item_count,
  input  logic [NUM_CORES-1:0]     core_halted,
  input  logic [NUM_CORES-1:0]     core_exception,
  output logic [NUM_CORES-1:0]     core_reset_n,
  output logic [NUM_CORES-1:0]     core_run,
  output logic [NUM_CORES-1:0]     enable_write_data_ram,
  output logic [ADDRESS_WIDTH-1:0] rw_address,
  output logic [WORD_WIDTH-1:0]    write_data,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [CW-1:0]            error_core,
  output logic [15:0]              items_completed,
  output logic [2:0]               dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SCAN    = 3'd1,
    S_WRITE   = 3'd2,
    S_RELEASE = 3'd3,
    S_DONE    = 3'd4,
    S_ERROR   = 3'd5
  } state_t;

  state_t                   state_q, state_d;
  logic [15:0]              count_q, count_d;
  logic [15:0]              next_item_q, next_item_d;
  logic [15:0]              items_completed_q, items_completed_d;
  logic [CW-1:0]            rr_q, rr_d;
  logic [CW-1:0]            sel_q, sel_d;
  logic [NUM_CORES-1:0]     core_busy_q, core_busy_d;
  logic [NUM_CORES-1:0]     run_old_q, run_old_d;
  logic [NUM_CORES-1:0]     core_run_q, core_run_d;
  logic [NUM_CORES-1:0]     core_reset_n_q, core_reset_n_d;
  logic [NUM_CORES-1:0]     wr_en_q, wr_en_d;
  logic [ADDRESS_WIDTH-1:0] rw_address_q, rw_address_d;
  logic [WORD_WIDTH-1:0]    write_data_q, write_data_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     done_pend_q, done_pend_d;
  logic                     error_q, error_d;
  logic [CW-1:0]            error_core_q, error_core_d;

  logic [NUM_CORES-1:0]     free_vec;
  logic [NUM_CORES-1:0]     retire_vec;
  logic [NUM_CORES-1:0]     exc_vec;
  logic [15:0]              retire_cnt;
  logic [CW-1:0]            exc_idx;
  logic                     abort;
  logic [CW-1:0]            pick_idx;
  logic                     pick_found;
  logic [CW-1:0]            pick_low;
  logic [CW-1:0]            pick_high;
  logic                     pick_high_found;

  // Per-core status: who is free, who is retiring, who raised an exception.
  // run_old marks a core whose run has been high for a full cycle, so a stale
  // halted level coming out of reset is ignored for the first cycle.
  always_comb begin
    free_vec   = ~core_busy_q;
    retire_vec = core_busy_q & run_old_q & core_halted;
    exc_vec    = core_busy_q & core_exception;
    abort      = |exc_vec;
    retire_cnt = '0;
    exc_idx    = '0;
    for (int c = 0; c < NUM_CORES; c++) begin
      retire_cnt = retire_cnt + {15'd0, retire_vec[c]};
    end
    for (int c = NUM_CORES - 1; c >= 0; c--) begin
      if (exc_vec[c]) exc_idx = CW'(c);
    end
  end

  // Round-robin pick: first free core at or after rr, else the lowest free one.
  always_comb begin
    pick_low        = '0;
    pick_high       = '0;
    pick_found      = 1'b0;
    pick_high_found = 1'b0;
    for (int c = NUM_CORES - 1; c >= 0; c--) begin
      if (free_vec[c]) begin
        pick_low   = CW'(c);
        pick_found = 1'b1;
        if (CW'(c) >= rr_q) begin
          pick_high       = CW'(c);
          pick_high_found = 1'b1;
        end
      end
    end
    pick_idx = pick_high_found ? pick_high : pick_low;
  end

  // Next-state and output logic: retire bookkeeping first, then the FSM, then
  // the abort path, which overrides everything else.
  always_comb begin
    state_d           = state_q;
    count_d           = count_q;
    next_item_d       = next_item_q;
    items_completed_d = items_completed_q + retire_cnt;
    rr_d              = rr_q;
    sel_d             = sel_q;
    core_busy_d       = core_busy_q & ~retire_vec;
    run_old_d         = core_run_q & ~retire_vec;
    core_run_d        = core_run_q & ~retire_vec;
    core_reset_n_d    = core_reset_n_q & ~retire_vec;
    wr_en_d           = '0;
    rw_address_d      = rw_address_q;
    write_data_d      = write_data_q;
    busy_d            = busy_q;
    done_d            = 1'b0;
    done_pend_d       = done_pend_q;
    error_d           = error_q;
    error_core_d      = error_core_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (done_pend_q) begin
          // Zero-item job: report completion one cycle after entering DONE.
          done_d      = 1'b1;
          done_pend_d = 1'b0;
          busy_d      = 1'b0;
        end else if (start && !busy_q) begin
          count_d           = item_count;
          next_item_d       = '0;
          items_completed_d = '0;
          error_d           = 1'b0;
          busy_d            = 1'b1;
          if (item_count == 16'd0) begin
            state_d     = S_DONE;
            done_pend_d = 1'b1;
          end else begin
            state_d = S_SCAN;
          end
        end
      end
      S_SCAN: begin
        if (next_item_q < count_q && pick_found) begin
          sel_d              = pick_idx;
          wr_en_d[pick_idx]  = 1'b1;
          rw_address_d       = ITEM_ADDR;
          write_data_d       = WORD_WIDTH'(next_item_q);
          state_d            = S_WRITE;
        end else if (items_completed_q == count_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end
      end
      S_WRITE: begin
        state_d = S_RELEASE;
      end
      S_RELEASE: begin
        core_reset_n_d[sel_q] = 1'b1;
        core_run_d[sel_q]     = 1'b1;
        core_busy_d[sel_q]    = 1'b1;
        next_item_d           = next_item_q + 16'd1;
        rr_d                  = (sel_q == CW'(NUM_CORES - 1)) ? '0 : sel_q + CW'(1);
        state_d               = S_SCAN;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort) begin
      state_d           = S_ERROR;
      error_d           = 1'b1;
      error_core_d      = exc_idx;
      core_run_d        = '0;
      core_reset_n_d    = '0;
      core_busy_d       = '0;
      run_old_d         = '0;
      wr_en_d           = '0;
      busy_d            = 1'b0;
      done_d            = 1'b0;
      done_pend_d       = 1'b0;
      items_completed_d = items_completed_q;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q           <= S_IDLE;
      count_q           <= '0;
      next_item_q       <= '0;
      items_completed_q <= '0;
      rr_q              <= '0;
      sel_q             <= '0;
      core_busy_q       <= '0;
      run_old_q         <= '0;
      core_run_q        <= '0;
      core_reset_n_q    <= '0;
      wr_en_q           <= '0;
      rw_address_q      <= '0;
      write_data_q      <= '0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      done_pend_q       <= 1'b0;
      error_q           <= 1'b0;
      error_core_q      <= '0;
    end else begin
      state_q           <= state_d;
      count_q           <= count_d;
      next_item_q       <= next_item_d;
      items_completed_q <= items_completed_d;
      rr_q              <= rr_d;
      sel_q             <= sel_d;
      core_busy_q       <= core_busy_d;
      run_old_q         <= run_old_d;
      core_run_q        <= core_run_d;
      core_reset_n_q    <= core_reset_n_d;
      wr_en_q           <= wr_en_d;
      rw_address_q      <= rw_address_d;
      write_data_q      <= write_data_d;
      busy_q            <= busy_d;
      done_q            <= done_d;
      done_pend_q       <= done_pend_d;
      error_q           <= error_d;
      error_core_q      <= error_core_d;
    end
  end

  assign core_reset_n          = core_reset_n_q;
  assign core_run              = core_run_q;
  assign enable_write_data_ram = wr_en_q;
  assign rw_address            = rw_address_q;
  assign write_data            = write_data_q;
  assign busy                  = busy_q;
  assign done                  = done_q;
  assign error                 = error_q;
  assign error_core            = error_core_q;
  assign items_completed       = items_completed_q;
  assign dbg_state             = state_q;

endmodule

// File: tb/tb_shader_dispatch_scheduler.sv
// Bench for shader_dispatch_scheduler: emulated cores, a strobe scoreboard fed
// from a round-robin launch model, and directed boundary scenarios.
module tb_shader_dispatch_scheduler;
  localparam int NC   = 4;
  localparam int AW   = 16;
  localparam int WW   = 32;
  localparam int CW   = 2;
  localparam int SB_W = 24;

  logic          clock          = 1'b0;
  logic          reset_n        = 1'b0;
  logic          start          = 1'b0;
  logic [15:0]   item_count     = '0;
  logic [NC-1:0] core_halted    = '0;
  logic [NC-1:0] core_exception = '0;
  logic [NC-1:0] core_reset_n;
  logic [NC-1:0] core_run;
  logic [NC-1:0] enable_write_data_ram;
  logic [AW-1:0] rw_address;
  logic [WW-1:0] write_data;
  logic          busy;
  logic          done;
  logic          error;
  logic [CW-1:0] error_core;
  logic [15:0]   items_completed;
  logic [2:0]    dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;

  // Scoreboard entries: {core[7:0], item[15:0]}.
  logic [SB_W-1:0] exp_q[$];
  int              model_rr = 0;

  // Core emulation controls.
  logic          auto_mode   = 1'b1;
  int            lat         = 5;
  logic [NC-1:0] manual_halt = '0;
  int            run_cnt[NC];

  // Monitor state.
  logic [SB_W-1:0] mon_e;
  int              pend_core = -1;
  int              pend_age  = 0;

  shader_dispatch_scheduler #(
    .NUM_CORES    (NC),
    .ADDRESS_WIDTH(AW),
    .WORD_WIDTH   (WW),
    .ITEM_ADDR    (16'h0000)
  ) dut (
    .clock                (clock),
    .reset_n              (reset_n),
    .start                (start),
    .item_count           (item_count),
    .core_halted          (core_halted),
    .core_exception       (core_exception),
    .core_reset_n         (core_reset_n),
    .core_run             (core_run),
    .enable_write_data_ram(enable_write_data_ram),
    .rw_address           (rw_address),
    .write_data           (write_data),
    .busy                 (busy),
    .done                 (done),
    .error                (error),
    .error_core           (error_core),
    .items_completed      (items_completed),
    .dbg_state            (dbg_state)
  );

  // Clock.
  always #5 clock = ~clock;

  // Watchdog.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, expected the bench to finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Emulated cores: halted rises lat cycles after run in auto mode, or
  // follows manual_halt while running in manual mode.
  always @(negedge clock) begin
    for (int c = 0; c < NC; c++) begin
      if (core_run[c] === 1'b1) run_cnt[c] = run_cnt[c] + 1;
      else run_cnt[c] = 0;
      core_halted[c] = (core_run[c] === 1'b1) &&
                       (auto_mode ? (run_cnt[c] >= lat) : manual_halt[c]);
    end
  end

  // Monitor: every write strobe pops one expected launch; two cycles later
  // that core must be running.
  always @(negedge clock) begin
    if (reset_n !== 1'b1) begin
      pend_core = -1;
    end else begin
      if (pend_core >= 0) begin
        pend_age++;
        if (pend_age == 2) begin
          check("launch_run_high", 32'(core_run[pend_core]), 1);
          pend_core = -1;
        end
      end
      if (enable_write_data_ram !== '0) begin
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL unexpected_strobe: got strobe %b data %0d, expected no strobe",
                   enable_write_data_ram, write_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("strobe_core", 32'(enable_write_data_ram), 32'(1) << mon_e[23:16]);
          check("write_data", write_data, 32'(mon_e[15:0]));
          check("rw_address", 32'(rw_address), 32'h0);
          check("core_held_in_reset", 32'(core_reset_n & enable_write_data_ram), 0);
          pend_core = int'(mon_e[23:16]);
          pend_age  = 0;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check_reset_values();
    check("rst_core_reset_n", 32'(core_reset_n), 0);
    check("rst_core_run", 32'(core_run), 0);
    check("rst_strobe", 32'(enable_write_data_ram), 0);
    check("rst_rw_address", 32'(rw_address), 0);
    check("rst_write_data", write_data, 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_error", 32'(error), 0);
    check("rst_error_core", 32'(error_core), 0);
    check("rst_items_completed", 32'(items_completed), 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick(2);
    check_reset_values();
    exp_q.delete();
    model_rr = 0;
    reset_n  = 1'b1;
    tick(1);
  endtask

  task automatic wait_run(input logic [NC-1:0] mask, input int budget, input string name);
    int cyc;
    cyc = 0;
    while ((core_run & mask) !== mask && cyc < budget) begin
      @(negedge clock);
      cyc++;
    end
    check(name, 32'(core_run & mask), 32'(mask));
  endtask

  task automatic wait_done(input int budget);
    int cyc;
    cyc = 0;
    while (done !== 1'b1 && cyc < budget) begin
      @(negedge clock);
      cyc++;
    end
    check("done_seen", 32'(done), 1);
  endtask

  // One job with uniform core latency: launches follow strict round robin
  // from the current pointer, item indices ascending.
  task automatic run_job(input int cnt, input int l);
    auto_mode = 1'b1;
    lat       = l;
    for (int i = 0; i < cnt; i++) exp_q.push_back({8'((model_rr + i) % NC), 16'(i)});
    model_rr   = (model_rr + cnt) % NC;
    item_count = 16'(cnt);
    start      = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("start_clears_error", 32'(error), 0);
    check("busy_after_start", 32'(busy), 1);
    check("no_strobe_in_first_scan", 32'(enable_write_data_ram), 0);
    @(negedge clock);
    check("first_strobe_latency", 32'(enable_write_data_ram != '0), 1);
    // A start while busy must be ignored.
    item_count = 16'($urandom_range(1, 40));
    start      = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done(cnt * (l + 12) + 60);
    check("items_completed_at_done", 32'(items_completed), 32'(cnt));
    check("busy_low_at_done", 32'(busy), 0);
    check("runs_low_at_done", 32'(core_run), 0);
    check("all_launches_seen", 32'(exp_q.size()), 0);
    @(negedge clock);
    check("done_single_pulse", 32'(done), 0);
  endtask

  initial begin
    // Reset state.
    do_reset();

    // Single item, core 0 halts 5 cycles after run.
    run_job(1, 5);

    // Six items from rr=0: cores 0,1,2,3,0,1.
    do_reset();
    run_job(6, 10);

    // Empty job: done two cycles after start, nothing launched.
    item_count = 16'd0;
    start      = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("zero_busy", 32'(busy), 1);
    check("zero_done_early", 32'(done), 0);
    @(negedge clock);
    check("zero_done_latency", 32'(done), 1);
    check("zero_items_completed", 32'(items_completed), 0);
    @(negedge clock);
    check("zero_done_pulse", 32'(done), 0);
    check("zero_busy_end", 32'(busy), 0);
    check("zero_no_run", 32'(core_run), 0);

    // Randomized jobs.
    for (int j = 0; j < 5; j++) begin
      run_job($urandom_range(1, 12), $urandom_range(1, 15));
    end

    // Cores 1 and 2 halt in the same cycle and are relaunched.
    do_reset();
    auto_mode   = 1'b0;
    manual_halt = '0;
    for (int i = 0; i < 4; i++) exp_q.push_back({8'(i), 16'(i)});
    exp_q.push_back({8'd1, 16'd4});
    exp_q.push_back({8'd2, 16'd5});
    model_rr   = 3;
    item_count = 16'd6;
    start      = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_run(4'hf, 40, "pair_all_running");
    check("pair_count_before", 32'(items_completed), 0);
    #1 manual_halt = 4'b0110;
    @(negedge clock);
    @(negedge clock);
    check("pair_count_step", 32'(items_completed), 2);
    check("pair_runs_dropped", 32'(core_run), 32'h9);
    #1 manual_halt = '0;
    wait_run(4'hf, 40, "pair_relaunched");
    #1 manual_halt = 4'hf;
    wait_done(40);
    check("pair_items_completed", 32'(items_completed), 6);
    check("pair_all_launches", 32'(exp_q.size()), 0);
    auto_mode = 1'b1;
    tick(2);

    // Exception on busy core 2 aborts; exception on a free core is ignored.
    do_reset();
    lat = 100;
    for (int i = 0; i < 4; i++) exp_q.push_back({8'(i), 16'(i)});
    item_count = 16'd4;
    start      = 1'b1;
    @(negedge clock);
    start          = 1'b0;
    core_exception = 4'b1000;
    @(negedge clock);
    core_exception = '0;
    check("free_core_exc_ignored", 32'(error), 0);
    wait_run(4'b0100, 40, "core2_running");
    core_exception = 4'b0100;
    @(negedge clock);
    core_exception = '0;
    check("exc_error", 32'(error), 1);
    check("exc_error_core", 32'(error_core), 2);
    check("exc_runs_low", 32'(core_run), 0);
    check("exc_resets_low", 32'(core_reset_n), 0);
    check("exc_busy_low", 32'(busy), 0);
    exp_q.delete();
    model_rr = 3;
    tick(10);
    check("exc_error_sticky", 32'(error), 1);
    run_job(2, 5);

    // Reset mid-job with three cores busy, then a clean job.
    do_reset();
    lat = 100;
    for (int i = 0; i < 8; i++) exp_q.push_back({8'(i % NC), 16'(i)});
    item_count = 16'd8;
    start      = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_run(4'b0111, 40, "three_running");
    reset_n = 1'b0;
    @(negedge clock);
    check_reset_values();
    exp_q.delete();
    model_rr = 0;
    reset_n  = 1'b1;
    tick(1);
    run_job(2, 5);

    tick(3);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
